maxpool_2x2: RTL and testbench

Downstream neighbour of the convolution stage. After the convolution engine has filled layer-0 memory with a 64×64 feature map (20-bit signed, ReLU'd), this block reads that map and computes a 2×2, stride-2 max-pool. It writes the 32×32 result into layer-1 memory over the shared memory port (`crd`/`cwr`/`csel`). The top-level sequencer starts it with a one-cycle `start` pulse and waits for `done`.

---
 rtl/maxpool_2x2_if.sv | 43 ++++
 rtl/maxpool_2x2.sv | 141 ++++++++++++++
 tb/tb_maxpool_2x2.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_2x2_if.sv
// Handshake and memory-port bundle for the 2x2 max-pool stage.
// master = pooling block, slave = sequencer plus shared memory.
interface maxpool_2x2_if #(
  parameter int DW = 20,
  parameter int AW = 12
);
  logic          start;
  logic          busy;
  logic          done;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  modport master (
    input  start,
    input  cdata_rd,
    output busy,
    output done,
    output crd,
    output caddr_rd,
    output cwr,
    output caddr_wr,
    output cdata_wr,
    output csel
  );

  modport slave (
    output start,
    output cdata_rd,
    input  busy,
    input  done,
    input  crd,
    input  caddr_rd,
    input  cwr,
    input  caddr_wr,
    input  cdata_wr,
    input  csel
  );
endinterface

// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 max-pool from layer-0 into layer-1 memory, 6 cycles/window.
// Define MAXPOOL_RELU_EN to clamp negative samples to 0 before comparing.
module maxpool_2x2 #(
  parameter int         IMG_W  = 64,
  parameter int         DW     = 20,
  parameter int         AW     = 12,
  parameter logic [2:0] SEL_RD = 3'd1,
  parameter logic [2:0] SEL_WR = 3'd3
) (
  input logic          clk,
  input logic          reset,
  maxpool_2x2_if.master bus
);

  localparam int LW   = $clog2(IMG_W);
  localparam int HW   = IMG_W / 2;
  localparam int KW   = 2 * (LW - 1);
  localparam int NWIN = HW * HW;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    RD3,
    CAP,
    WR,
    DONE
  } state_t;

  state_t                state;
  logic [KW-1:0]         win;
  logic [KW-1:0]         win_nx;
  logic                  last;
  logic signed [DW-1:0]  mx;
  logic signed [DW-1:0]  samp;
  logic signed [DW-1:0]  pick;

  // Window k = {r, c}; pixel address = {2r+dy, 2c+dx}.
  function automatic logic [AW-1:0] rd_addr(
    input logic [KW-1:0] k,
    input logic          dy,
    input logic          dx
  );
    logic [2*LW-1:0] a;
    a = {k[KW-1:LW-1], dy, k[LW-2:0], dx};
    return AW'(a);
  endfunction

  always_comb begin
    samp = bus.cdata_rd;
`ifdef MAXPOOL_RELU_EN
    if (bus.cdata_rd[DW-1])
      samp = '0;
`endif
    pick = (samp > mx) ? samp : mx;
  end

  assign win_nx = win + KW'(1);
  assign last   = (win == KW'(NWIN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      win          <= '0;
      mx           <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.crd      <= 1'b0;
      bus.caddr_rd <= '0;
      bus.cwr      <= 1'b0;
      bus.caddr_wr <= '0;
      bus.cdata_wr <= '0;
      bus.csel     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= RD0;
            bus.busy     <= 1'b1;
            bus.crd      <= 1'b1;
            bus.csel     <= SEL_RD;
            bus.caddr_rd <= rd_addr(win, 1'b0, 1'b0);
          end
        end
        RD0: begin
          state        <= RD1;
          bus.caddr_rd <= rd_addr(win, 1'b0, 1'b1);
        end
        RD1: begin
          state        <= RD2;
          mx           <= samp;
          bus.caddr_rd <= rd_addr(win, 1'b1, 1'b0);
        end
        RD2: begin
          state        <= RD3;
          mx           <= pick;
          bus.caddr_rd <= rd_addr(win, 1'b1, 1'b1);
        end
        RD3: begin
          state   <= CAP;
          mx      <= pick;
          bus.crd <= 1'b0;
        end
        CAP: begin
          state        <= WR;
          mx           <= pick;
          bus.cwr      <= 1'b1;
          bus.csel     <= SEL_WR;
          bus.caddr_wr <= AW'(win);
          bus.cdata_wr <= pick;
        end
        WR: begin
          bus.cwr <= 1'b0;
          if (last) begin
            state    <= DONE;
            win      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            state        <= RD0;
            win          <= win_nx;
            bus.crd      <= 1'b1;
            bus.csel     <= SEL_RD;
            bus.caddr_rd <= rd_addr(win_nx, 1'b0, 1'b0);
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_rd_wr: assert property (
    @(posedge clk) disable iff (reset) !(bus.crd && bus.cwr)
  );

endmodule

// File: tb/tb_maxpool_2x2.sv
// Directed bench for maxpool_2x2 with a 1-cycle-latency memory model.
// Covers reset, ramp image, negative windows, timing and ignored starts.
module tb_maxpool_2x2;

  logic clk;
  logic reset;

  maxpool_2x2_if #(.DW(20), .AW(12)) bus ();

  maxpool_2x2 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [19:0] l0 [4096];
  logic [19:0] l1 [1024];
  logic [19:0] rdq;
  int          wr_cnt;
  int          done_cnt;
  int          both_cnt;
  int          badsel_cnt;
  int          total;
  int          bad;

  logic        snap_crd  [0:7];
  logic [11:0] snap_ra   [0:7];
  logic        snap_cwr  [0:7];
  logic [2:0]  snap_sel  [0:7];
  logic        snap_busy [0:7];

  assign bus.cdata_rd = rdq;

  always @(posedge clk) begin
    if (bus.crd)
      rdq <= l0[bus.caddr_rd];
    if (bus.cwr) begin
      l1[bus.caddr_wr[9:0]] <= bus.cdata_wr;
      wr_cnt <= wr_cnt + 1;
      if (bus.csel != 3'd3)
        badsel_cnt <= badsel_cnt + 1;
    end
    if (bus.crd && bus.cwr)
      both_cnt <= both_cnt + 1;
    if (bus.done)
      done_cnt <= done_cnt + 1;
  end

  function automatic logic [19:0] ramp_exp(input int k);
    return 20'(128 * (k / 32) + 2 * (k % 32) + 65);
  endfunction

  task automatic load_ramp();
    for (int a = 0; a < 4096; a++)
      l0[a] = 20'(a);
    for (int i = 0; i < 1024; i++)
      l1[i] = 20'hAAAAA;
  endtask

  task automatic clr_counts();
    wr_cnt     = 0;
    done_cnt   = 0;
    both_cnt   = 0;
    badsel_cnt = 0;
  endtask

  // Pulse start, follow the run up to 8 cycles past done (bounded).
  task automatic run_pool(
    input  int   inj,
    input  bit   inj_done,
    output int   done_cyc,
    output logic busy_at_done
  );
    clr_counts();
    done_cyc     = -1;
    busy_at_done = 1'bx;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 7000; cyc++) begin
      if (cyc > 1)
        @(negedge clk);
      bus.start = (cyc == inj);
      if (cyc <= 6) begin
        snap_crd[cyc]  = bus.crd;
        snap_ra[cyc]   = bus.caddr_rd;
        snap_cwr[cyc]  = bus.cwr;
        snap_sel[cyc]  = bus.csel;
        snap_busy[cyc] = bus.busy;
      end
      if (bus.done && done_cyc < 0) begin
        done_cyc     = cyc;
        busy_at_done = bus.busy;
        if (inj_done)
          bus.start = 1'b1;
      end
      if (done_cyc > 0 && cyc >= done_cyc + 8)
        break;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [55:0] outs;
    reset     = 1'b1;
    bus.start = 1'b0;
    clr_counts();
    #2;
    outs = {bus.busy, bus.done, bus.crd, bus.cwr, bus.caddr_rd,
            bus.caddr_wr, bus.cdata_wr, bus.csel};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_init got=%h want=0", outs);
    end
    load_ramp();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    outs = {bus.busy, bus.done, bus.crd, bus.cwr, bus.caddr_rd,
            bus.caddr_wr, bus.cdata_wr, bus.csel};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_async got=%h want=0", outs);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ramp();
    int   dc;
    logic bd;
    int   miss;
    load_ramp();
    run_pool(0, 1'b0, dc, bd);
    total++;
    if ({snap_busy[1], snap_crd[1], snap_sel[1], snap_ra[1]}
        !== {1'b1, 1'b1, 3'd1, 12'd0}) begin
      bad++;
      $display("FAIL t1_rd0 got=%b/%b/%0d/%0d want=1/1/1/0",
               snap_busy[1], snap_crd[1], snap_sel[1], snap_ra[1]);
    end
    total++;
    if ({snap_crd[2], snap_ra[2]} !== {1'b1, 12'd1}) begin
      bad++;
      $display("FAIL t2_rd1 got=%b/%0d want=1/1", snap_crd[2], snap_ra[2]);
    end
    total++;
    if ({snap_crd[3], snap_ra[3]} !== {1'b1, 12'd64}) begin
      bad++;
      $display("FAIL t3_rd2 got=%b/%0d want=1/64", snap_crd[3], snap_ra[3]);
    end
    total++;
    if ({snap_crd[4], snap_ra[4]} !== {1'b1, 12'd65}) begin
      bad++;
      $display("FAIL t4_rd3 got=%b/%0d want=1/65", snap_crd[4], snap_ra[4]);
    end
    total++;
    if ({snap_crd[5], snap_cwr[5]} !== 2'b00) begin
      bad++;
      $display("FAIL t5_cap got=%b%b want=00", snap_crd[5], snap_cwr[5]);
    end
    total++;
    if ({snap_cwr[6], snap_crd[6], snap_sel[6]} !== {1'b1, 1'b0, 3'd3}) begin
      bad++;
      $display("FAIL t6_wr got=%b/%b/%0d want=1/0/3",
               snap_cwr[6], snap_crd[6], snap_sel[6]);
    end
    total++;
    if (dc !== 6145 || bd !== 1'b0) begin
      bad++;
      $display("FAIL done_cycle got=%0d busy=%b want=6145 busy=0", dc, bd);
    end
    total++;
    if (wr_cnt !== 1024 || done_cnt !== 1) begin
      bad++;
      $display("FAIL ramp_counts got=%0d/%0d want=1024/1", wr_cnt, done_cnt);
    end
    total++;
    if (both_cnt !== 0 || badsel_cnt !== 0) begin
      bad++;
      $display("FAIL ramp_strobes got=%0d/%0d want=0/0",
               both_cnt, badsel_cnt);
    end
    total++;
    if (l1[0] !== 20'd65 || l1[1] !== 20'd67 || l1[31] !== 20'd127) begin
      bad++;
      $display("FAIL ramp_row0 got=%0d/%0d/%0d want=65/67/127",
               l1[0], l1[1], l1[31]);
    end
    total++;
    if (l1[32] !== 20'd193 || l1[1023] !== 20'd4095) begin
      bad++;
      $display("FAIL ramp_far got=%0d/%0d want=193/4095", l1[32], l1[1023]);
    end
    miss = 0;
    for (int i = 0; i < 1024; i++)
      if (l1[i] !== ramp_exp(i))
        miss++;
    total++;
    if (miss !== 0) begin
      bad++;
      $display("FAIL ramp_all got=%0d wrong want=0 wrong", miss);
    end
  endtask

  task automatic set_win(
    input int k,
    input logic [19:0] a,
    input logic [19:0] b,
    input logic [19:0] c,
    input logic [19:0] d
  );
    int base;
    base = 128 * (k / 32) + 2 * (k % 32);
    l0[base]      = a;
    l0[base + 1]  = b;
    l0[base + 64] = c;
    l0[base + 65] = d;
  endtask

  task automatic test_negative();
    int          dc;
    logic        bd;
    logic [19:0] e0;
    logic [19:0] e3;
    load_ramp();
    set_win(0, -20'sd5, -20'sd3, -20'sd7, -20'sd9);
    set_win(1, 20'd7, 20'd7, 20'd7, 20'd7);
    set_win(2, 20'd50, 20'd20, 20'd30, 20'd40);
    set_win(3, -20'sd100, -20'sd200, -20'sd50, -20'sd60);
    set_win(4, 20'd1, 20'd2, 20'd3, 20'h7FFFF);
    set_win(5, 20'h80000, 20'd1, 20'h80000, 20'd0);
`ifdef MAXPOOL_RELU_EN
    e0 = 20'd0;
    e3 = 20'd0;
`else
    e0 = 20'hFFFFD;
    e3 = 20'hFFFCE;
`endif
    run_pool(0, 1'b0, dc, bd);
    total++;
    if (l1[0] !== e0) begin
      bad++;
      $display("FAIL neg_win0 got=%h want=%h", l1[0], e0);
    end
    total++;
    if (l1[1] !== 20'd7) begin
      bad++;
      $display("FAIL equal_win got=%h want=7", l1[1]);
    end
    total++;
    if (l1[2] !== 20'd50) begin
      bad++;
      $display("FAIL first_max got=%h want=32", l1[2]);
    end
    total++;
    if (l1[3] !== e3) begin
      bad++;
      $display("FAIL neg_win3 got=%h want=%h", l1[3], e3);
    end
    total++;
    if (l1[4] !== 20'h7FFFF || l1[5] !== 20'd1) begin
      bad++;
      $display("FAIL sign_edges got=%h/%h want=7ffff/1", l1[4], l1[5]);
    end
    total++;
    if (l1[6] !== ramp_exp(6) || wr_cnt !== 1024) begin
      bad++;
      $display("FAIL neg_rest got=%h/%0d want=%h/1024",
               l1[6], wr_cnt, ramp_exp(6));
    end
  endtask

  task automatic test_start_ignored();
    int   dc;
    logic bd;
    load_ramp();
    run_pool(33, 1'b1, dc, bd);
    total++;
    if (wr_cnt !== 1024 || done_cnt !== 1) begin
      bad++;
      $display("FAIL ign_counts got=%0d/%0d want=1024/1", wr_cnt, done_cnt);
    end
    total++;
    if (dc !== 6145) begin
      bad++;
      $display("FAIL ign_done_cycle got=%0d want=6145", dc);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.crd !== 1'b0) begin
      bad++;
      $display("FAIL ign_restart got=%b/%b want=0/0", bus.busy, bus.crd);
    end
    total++;
    if (l1[5] !== 20'd75 || l1[1023] !== 20'd4095) begin
      bad++;
      $display("FAIL ign_data got=%0d/%0d want=75/4095", l1[5], l1[1023]);
    end
  endtask

  task automatic test_reset_midrun();
    int   dc;
    logic bd;
    int   miss;
    load_ramp();
    clr_counts();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (602) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.crd, bus.cwr} !== 3'b000 || wr_cnt !== 100) begin
      bad++;
      $display("FAIL mid_reset got=%b%b%b/%0d want=000/100",
               bus.busy, bus.crd, bus.cwr, wr_cnt);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (wr_cnt !== 100 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_nowrite got=%0d/%b want=100/0", wr_cnt, bus.busy);
    end
    run_pool(0, 1'b0, dc, bd);
    total++;
    if ({snap_crd[1], snap_ra[1]} !== {1'b1, 12'd0} || dc !== 6145) begin
      bad++;
      $display("FAIL mid_restart got=%b/%0d/%0d want=1/0/6145",
               snap_crd[1], snap_ra[1], dc);
    end
    miss = 0;
    for (int i = 0; i < 1024; i++)
      if (l1[i] !== ramp_exp(i))
        miss++;
    total++;
    if (miss !== 0 || wr_cnt !== 1024) begin
      bad++;
      $display("FAIL mid_ramp got=%0d wrong/%0d writes want=0/1024",
               miss, wr_cnt);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rdq   = '0;
    test_reset();
    test_ramp();
    test_negative();
    test_start_ignored();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
